ram_bank: RTL

Parametrised synchronous single-port RAM; successor to the fixed 8K x 16 RAM used by the OPC5LS co-processor. Adds configurable width and depth, per-byte write enables, read-first or write-first write behaviour, one or two cycles of read latency with a data-valid strobe, and an optional clear-on-reset sequencer with a busy flag. Sits between the CPU bus interface and the memory array, and replaces the fixed RAM wherever it is instantiated.

---
 rtl/ram_pkg.sv | 18 +
 rtl/ram_clear_ctl.sv | 83 ++++++++
 rtl/ram_bank.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the ram_bank memory block: write-mode codes,
// sequencer state encodings and a width helper.
package ram_pkg;

    localparam int READ_FIRST  = 0;
    localparam int WRITE_FIRST = 1;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Number of byte lanes in a data word.
    function automatic int nbytes(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/ram_clear_ctl.sv
// Clear sequencer for ram_bank: owns the CLEAR/READY state, the clear
// address counter and the busy flag, and presents a write port that fills
// the array with the clear value after reset.
module ram_clear_ctl
    import ram_pkg::*;
#(
    parameter int ADDR_W         = 13,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              i_reset,
    output state_t            o_state,
    output logic              o_busy,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_addr
);

    localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1'b1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_busy;

    state_t            w_state_nxt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic              w_busy_nxt;
    logic              w_clr_we;

    // State, counter and busy registers; reset restarts the clear from 0.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // Next-state logic: walk every address once, then open for traffic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_busy_nxt  = r_busy;
        w_clr_we    = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_busy_nxt = 1'b1;
                if (CLEAR_ON_RESET != 0) begin
                    // No array write on an edge where reset is still asserted.
                    w_clr_we  = ~i_reset;
                    w_cnt_nxt = r_cnt + CNT_ONE;
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt = ST_READY;
                        w_busy_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = ST_CLEAR;
                    end
                end else begin
                    w_state_nxt = ST_READY;
                    w_busy_nxt  = 1'b0;
                end
            end
            ST_READY: begin
                w_busy_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = ST_CLEAR;
                w_cnt_nxt   = '0;
                w_busy_nxt  = 1'b1;
            end
        endcase
    end

    assign o_state    = r_state;
    assign o_busy     = r_busy;
    assign o_clr_we   = w_clr_we;
    assign o_clr_addr = r_cnt;

endmodule

// File: rtl/ram_bank.sv
// Parametrised synchronous single-port RAM with byte enables, read-first or
// write-first behaviour, 1- or 2-cycle registered read latency with a
// data-valid strobe, and an optional clear-after-reset sequencer.
module ram_bank
    import ram_pkg::*;
#(
    parameter int                DATA_W         = 16,
    parameter int                ADDR_W         = 13,
    parameter int                RD_LATENCY     = 1,
    parameter int                WRITE_MODE     = 0,
    parameter int                CLEAR_ON_RESET = 1,
    parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0,
    parameter string             MEM_INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cs_b,
    input  logic                  rnw,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W-1:0]     din,
    output logic [DATA_W-1:0]     dout,
    output logic                  dvalid,
    output logic                  busy
);

    localparam int NB    = nbytes(DATA_W);
    localparam int DEPTH = 2 ** ADDR_W;

    generate
        if ((DATA_W % 8) != 0) begin : g_bad_data_w
            $error("ram_bank: DATA_W must be a multiple of 8");
        end
        if ((RD_LATENCY != 1) && (RD_LATENCY != 2)) begin : g_bad_latency
            $error("ram_bank: RD_LATENCY must be 1 or 2");
        end
        // With the clear sequencer enabled any preloaded image is wiped
        // before the first access; such configurations use CLEAR_ON_RESET=0.
        if ((MEM_INIT_FILE != "") && (CLEAR_ON_RESET != 0)) begin : g_image_cleared
        end
    endgenerate

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];

    state_t            w_state;
    logic              w_busy;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_acc;
    logic              w_wr;
    logic [DATA_W-1:0] w_old;
    logic [DATA_W-1:0] w_merged;
    logic [DATA_W-1:0] w_res;

    logic [DATA_W-1:0] r_p1_data;
    logic              r_p1_upd;
    logic              r_p1_vld;
    logic [DATA_W-1:0] r_p2_data;
    logic              r_p2_vld;

    ram_clear_ctl #(
        .ADDR_W         (ADDR_W),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_ctl (
        .clk        (clk),
        .i_reset    (reset),
        .o_state    (w_state),
        .o_busy     (w_busy),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr)
    );

    assign w_acc = (w_state == ST_READY) && !w_busy && !cs_b && !reset;
    assign w_wr  = w_acc && !rnw;
    assign w_old = r_mem[address];

    // Byte-lane merge of the incoming data over the stored word.
    always_comb begin
        w_merged = w_old;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                w_merged[8*i +: 8] = din[8*i +: 8];
            end else begin
                w_merged[8*i +: 8] = w_old[8*i +: 8];
            end
        end
    end

    // Word presented on dout for this access: new data only for write-first writes.
    always_comb begin
        w_res = w_old;
        if (w_wr && (WRITE_MODE == WRITE_FIRST)) begin
            w_res = w_merged;
        end else begin
            w_res = w_old;
        end
    end

    // Array write port: the clear sequencer has priority over user writes.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= CLEAR_VALUE;
        end else if (w_wr) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) begin
                    r_mem[address][8*i +: 8] <= din[8*i +: 8];
                end
            end
        end
    end

    // First output stage: captures the result of each accepted access.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_p1_data <= '0;
            r_p1_upd  <= 1'b0;
            r_p1_vld  <= 1'b0;
        end else begin
            r_p1_upd <= w_acc;
            r_p1_vld <= w_acc && rnw;
            if (w_acc) begin
                r_p1_data <= w_res;
            end
        end
    end

    // Second output stage, used only when two cycles of latency are configured.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_p2_data <= '0;
            r_p2_vld  <= 1'b0;
        end else begin
            r_p2_vld <= r_p1_vld;
            if (r_p1_upd) begin
                r_p2_data <= r_p1_data;
            end
        end
    end

    assign dout   = (RD_LATENCY == 2) ? r_p2_data : r_p1_data;
    assign dvalid = (RD_LATENCY == 2) ? r_p2_vld  : r_p1_vld;
    assign busy   = w_busy;

endmodule
